sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_mem.sv | 40 ++++
 rtl/sync_fifo.sv | 106 ++++++++++
 tb/tb_sync_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the single-clock FIFO: default geometry and pointer/count widths.
// Pure constants and functions; no latency or flow-control implications.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that a completely full FIFO (occ == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and a registered read port.
// Read data appears one edge after rd_en and holds otherwise; no flow control of its own.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is intentionally not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 1-cycle registered read; push refused when full unless popping, pop refused when empty.
// Define SYNC_FIFO_COUNT_EN to expose occupancy count plus sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       write_data,
    output logic [WIDTH-1:0]       read_data,
    output logic                   empty,
    output logic                   full
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [PW-1:0] read_pointer, read_pointer_d;
    logic [PW-1:0] write_pointer, write_pointer_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          push_acc, pop_acc;

    // Flags depend only on registered occupancy, never on this cycle's push/pop.
    assign empty = (occ_q == '0);
    assign full  = (occ_q == CW'(DEPTH));

    always_comb begin
        push_acc        = push & (~full | pop);
        pop_acc         = pop & ~empty;
        read_pointer_d  = read_pointer;
        write_pointer_d = write_pointer;
        occ_d           = occ_q;
        if (push_acc) begin
            write_pointer_d = write_pointer + PW'(1);
        end
        if (pop_acc) begin
            read_pointer_d = read_pointer + PW'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_pointer  <= '0;
            write_pointer <= '0;
            occ_q         <= '0;
        end else begin
            read_pointer  <= read_pointer_d;
            write_pointer <= write_pointer_d;
            occ_q         <= occ_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_acc & ~rst),
        .wr_addr (write_pointer),
        .wr_data (write_data),
        .rd_en   (pop_acc & ~rst),
        .rd_addr (read_pointer),
        .rd_data (read_data)
    );

`ifdef SYNC_FIFO_COUNT_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push & full & ~pop) begin
                overflow_q <= 1'b1;
            end
            if (pop & empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign count     = occ_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: reference queue plus occupancy/pointer model driven alongside stimulus.
// Optional count/overflow/underflow outputs are checked when SYNC_FIFO_COUNT_EN is defined.
module tb_sync_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic         pop;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data;
    logic         empty;
    logic         full;
`ifdef SYNC_FIFO_COUNT_EN
    logic [$clog2(D):0] count;
    logic               overflow;
    logic               underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] sb[$];
    int           m_occ  = 0;
    int           m_rptr = 0;
    int           m_wptr = 0;
    logic [W-1:0] exp_rd = '0;
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    // Drive one cycle of stimulus, advance past the edge, and update the model.
    task automatic drive(input logic r, input logic p, input logic q, input logic [W-1:0] d);
        logic pa, qa;
        rst = r; push = p; pop = q; write_data = d;
        pa = !r && p && ((m_occ < D) || q);
        qa = !r && q && (m_occ > 0);
        if (!r && p && (m_occ == D) && !q) exp_ovf = 1'b1;
        if (!r && q && (m_occ == 0)) exp_unf = 1'b1;
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            m_occ = 0; m_rptr = 0; m_wptr = 0;
            exp_rd = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
        end else begin
            if (qa) begin
                exp_rd = sb.pop_front();
                m_rptr = (m_rptr + 1) % D;
                m_occ--;
            end
            if (pa) begin
                sb.push_back(d);
                m_wptr = (m_wptr + 1) % D;
                m_occ++;
            end
        end
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", read_data); end
        checks++; if (dut.read_pointer !== 2'd0 || dut.write_pointer !== 2'd0) begin
            errors++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", dut.read_pointer, dut.write_pointer);
        end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%b/%b exp=0/0/0", count, overflow, underflow);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, W'(i));
            checks++; if (full !== (m_occ == D)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, m_occ == D); end
        end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_flags got=f%b e%b exp=f1 e0", full, empty); end
        checks++; if (dut.write_pointer !== 2'd0) begin errors++; $display("FAIL fill_wptr_wrap got=%0d exp=0", dut.write_pointer); end
    endtask

    task automatic test_overflow();
        drive(1'b0, 1'b1, 1'b0, 8'h05);
        checks++; if (full !== 1'b1 || dut.write_pointer !== 2'd0 || dut.read_pointer !== 2'd0) begin
            errors++; $display("FAIL ovf_nochange got=f%b w%0d r%0d exp=f1 w0 r0", full, dut.write_pointer, dut.read_pointer);
        end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_flag got=%b/%0d exp=1/4", overflow, count); end
`endif
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            checks++; if (read_data !== exp_rd || exp_rd !== W'(i)) begin
                errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, read_data, W'(i));
            end
        end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_empty got=e%b f%b exp=e1 f0", empty, full); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (read_data !== 8'h04) begin errors++; $display("FAIL unf_hold got=%h exp=04", read_data); end
        checks++; if (dut.read_pointer !== 2'd0 || dut.write_pointer !== 2'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL unf_ptrs got=r%0d w%0d e%b exp=r0 w0 e1", dut.read_pointer, dut.write_pointer, empty);
        end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", underflow); end
`endif
        // Push+pop while empty: push taken, pop refused, no bypass.
        drive(1'b0, 1'b1, 1'b1, 8'h11);
        checks++; if (read_data !== 8'h04 || empty !== 1'b0) begin
            errors++; $display("FAIL empty_pushpop got=%h e%b exp=04 e0", read_data, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 2; i <= 4; i++) drive(1'b0, 1'b1, 1'b0, 8'h10 + W'(i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_prefull got=%b exp=1", full); end
        drive(1'b0, 1'b1, 1'b1, 8'h15);
        checks++; if (read_data !== 8'h11 || full !== 1'b1) begin
            errors++; $display("FAIL sim_pushpop got=%h f%b exp=11 f1", read_data, full);
        end
        for (int i = 2; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            checks++; if (read_data !== exp_rd || exp_rd !== (8'h10 + W'(i))) begin
                errors++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, read_data, 8'h10 + W'(i));
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_empty got=%b exp=1", empty); end
    endtask

    task automatic test_wrap_midreset();
        logic p, q;
        for (int i = 0; i < 10; i++) begin
            p = (i % 3) != 2;
            q = (i % 2) == 1;
            drive(1'b0, p, q, 8'h20 + W'(i));
            checks++; if (read_data !== exp_rd || empty !== (m_occ == 0) || full !== (m_occ == D)) begin
                errors++; $display("FAIL wrap[%0d] got=%h e%b f%b exp=%h e%b f%b",
                                   i, read_data, empty, full, exp_rd, m_occ == 0, m_occ == D);
            end
            checks++; if (dut.read_pointer !== 2'(m_rptr) || dut.write_pointer !== 2'(m_wptr)) begin
                errors++; $display("FAIL wrap_ptr[%0d] got=r%0d w%0d exp=r%0d w%0d", i, dut.read_pointer, dut.write_pointer, m_rptr, m_wptr);
            end
        end
        for (int n = 0; n < 2 * D && m_occ > 2; n++) drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int n = 0; n < 2 * D && m_occ < 2; n++) drive(1'b0, 1'b1, 1'b0, 8'h40 + W'(n));
        checks++; if (m_occ != 2 || empty !== 1'b0) begin errors++; $display("FAIL pre_reset_occ got=e%b exp=e0 occ2", empty); end
        drive(1'b1, 1'b1, 1'b1, 8'hAA);
        checks++; if (empty !== 1'b1 || full !== 1'b0 || read_data !== 8'h00) begin
            errors++; $display("FAIL midreset got=e%b f%b %h exp=e1 f0 00", empty, full, read_data);
        end
        checks++; if (dut.read_pointer !== 2'd0 || dut.write_pointer !== 2'd0) begin
            errors++; $display("FAIL midreset_ptrs got=r%0d w%0d exp=0/0", dut.read_pointer, dut.write_pointer);
        end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL midreset_cnt got=%0d/%b/%b exp=0/0/0", count, overflow, underflow);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (read_data !== 8'h00 || empty !== 1'b1) begin
            errors++; $display("FAIL post_reset_pop got=%h e%b exp=00 e1", read_data, empty);
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; write_data = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
